// File: rtl/axis_ingress_arbiter.sv
// rtl/axis_ingress_arbiter.sv - packet-granular round-robin arbiter feeding one AXIS mesh ingress
module axis_ingress_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TDATAW  = 32,
    parameter int TDESTW  = 4,
    parameter int TIDW    = 2,
    parameter int CNTW    = 16
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [NUM_REQ-1:0]        AXIS_S_TVALID,
    output logic [NUM_REQ-1:0]        AXIS_S_TREADY,
    input  logic [NUM_REQ*TDATAW-1:0] AXIS_S_TDATA,
    input  logic [NUM_REQ-1:0]        AXIS_S_TLAST,
    input  logic [NUM_REQ*TDESTW-1:0] AXIS_S_TDEST,
    output logic                      AXIS_M_TVALID,
    input  logic                      AXIS_M_TREADY,
    output logic [TDATAW-1:0]         AXIS_M_TDATA,
    output logic                      AXIS_M_TLAST,
    output logic [TDESTW-1:0]         AXIS_M_TDEST,
    output logic [TIDW-1:0]           AXIS_M_TID,
    output logic                      BUSY,
    output logic [TIDW-1:0]           GRANT_IDX,
    output logic [CNTW-1:0]           PKT_CNT
);

    typedef enum logic {
        ST_ARB = 1'b0,
        ST_PKT = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [TIDW-1:0]     grant_q, grant_d;
    logic [TIDW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [CNTW-1:0]     pkt_cnt_q, pkt_cnt_d;
    logic                m_valid_q, m_valid_d;
    logic [TDATAW-1:0]   m_data_q, m_data_d;
    logic                m_last_q, m_last_d;
    logic [TDESTW-1:0]   m_dest_q, m_dest_d;
    logic [TIDW-1:0]     m_tid_q, m_tid_d;

    logic                sel_valid;
    logic                sel_last;
    logic [TDATAW-1:0]   sel_data;
    logic [TDESTW-1:0]   sel_dest;

    logic                any_req;
    logic [TIDW-1:0]     rr_pick;
    int                  rr_dist;
    int                  best_dist;
    int                  next_ptr;

    logic                can_load;
    logic                s_hs;

    // Mux the granted requester's beat onto the internal select bus
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        sel_dest  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q == TIDW'(i)) begin
                sel_valid = AXIS_S_TVALID[i];
                sel_last  = AXIS_S_TLAST[i];
                sel_data  = AXIS_S_TDATA[i*TDATAW +: TDATAW];
                sel_dest  = AXIS_S_TDEST[i*TDESTW +: TDESTW];
            end
        end
    end

    // Round-robin pick: valid requester with the smallest upward distance from rr_ptr
    always_comb begin
        any_req   = 1'b0;
        rr_pick   = rr_ptr_q;
        best_dist = NUM_REQ;
        rr_dist   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rr_dist = i - int'(rr_ptr_q);
            if (rr_dist < 0) begin
                rr_dist = rr_dist + NUM_REQ;
            end
            if (AXIS_S_TVALID[i] && (rr_dist < best_dist)) begin
                best_dist = rr_dist;
                rr_pick   = TIDW'(i);
                any_req   = 1'b1;
            end
        end
    end

    // Next-state, ready generation and output-register load decision
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        rr_ptr_d      = rr_ptr_q;
        pkt_cnt_d     = pkt_cnt_q;
        m_valid_d     = m_valid_q;
        m_data_d      = m_data_q;
        m_last_d      = m_last_q;
        m_dest_d      = m_dest_q;
        m_tid_d       = m_tid_q;
        AXIS_S_TREADY = '0;
        next_ptr      = 0;

        // The output slot can take a beat when empty or being drained this cycle
        can_load = ~m_valid_q | AXIS_M_TREADY;
        s_hs     = (state_q == ST_PKT) && sel_valid && can_load;

        if (state_q == ST_PKT) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                AXIS_S_TREADY[i] = (grant_q == TIDW'(i)) && can_load;
            end
        end

        case (state_q)
            ST_ARB: begin
                if (any_req) begin
                    grant_d = rr_pick;
                    state_d = ST_PKT;
                end
            end
            ST_PKT: begin
                if (s_hs && sel_last) begin
                    pkt_cnt_d = pkt_cnt_q + CNTW'(1);
                    next_ptr  = int'(grant_q) + 1;
                    if (next_ptr >= NUM_REQ) begin
                        next_ptr = 0;
                    end
                    rr_ptr_d = TIDW'(next_ptr);
                    state_d  = ST_ARB;
                end
            end
            default: begin
                state_d = ST_ARB;
            end
        endcase

        if (s_hs) begin
            m_valid_d = 1'b1;
            m_data_d  = sel_data;
            m_last_d  = sel_last;
            m_dest_d  = sel_dest;
            m_tid_d   = grant_q;
        end else if (AXIS_M_TREADY) begin
            m_valid_d = 1'b0;
        end
    end

    // State, grant, counter and output slice registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= ST_ARB;
            grant_q   <= '0;
            rr_ptr_q  <= '0;
            pkt_cnt_q <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_last_q  <= 1'b0;
            m_dest_q  <= '0;
            m_tid_q   <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_ptr_q  <= rr_ptr_d;
            pkt_cnt_q <= pkt_cnt_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_last_q  <= m_last_d;
            m_dest_q  <= m_dest_d;
            m_tid_q   <= m_tid_d;
        end
    end

    assign AXIS_M_TVALID = m_valid_q;
    assign AXIS_M_TDATA  = m_data_q;
    assign AXIS_M_TLAST  = m_last_q;
    assign AXIS_M_TDEST  = m_dest_q;
    assign AXIS_M_TID    = m_tid_q;
    assign BUSY          = (state_q == ST_PKT);
    assign GRANT_IDX     = grant_q;
    assign PKT_CNT       = pkt_cnt_q;

endmodule

// File: tb/tb_axis_ingress_arbiter.sv
// tb/tb_axis_ingress_arbiter.sv - directed self-checking bench for axis_ingress_arbiter
module tb_axis_ingress_arbiter;

    localparam int NR  = 4;
    localparam int DW  = 32;
    localparam int DSW = 4;
    localparam int IW  = 2;
    localparam int CW  = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst;
    logic [NR-1:0]      s_tvalid;
    logic [NR-1:0]      s_tready;
    logic [NR*DW-1:0]   s_tdata;
    logic [NR-1:0]      s_tlast;
    logic [NR*DSW-1:0]  s_tdest;
    logic               m_tvalid;
    logic               m_tready;
    logic [DW-1:0]      m_tdata;
    logic               m_tlast;
    logic [DSW-1:0]     m_tdest;
    logic [IW-1:0]      m_tid;
    logic               busy;
    logic [IW-1:0]      grant_idx;
    logic [CW-1:0]      pkt_cnt;

    axis_ingress_arbiter #(
        .NUM_REQ(NR), .TDATAW(DW), .TDESTW(DSW), .TIDW(IW), .CNTW(CW)
    ) dut (
        .CLK(clk), .RST(rst),
        .AXIS_S_TVALID(s_tvalid), .AXIS_S_TREADY(s_tready),
        .AXIS_S_TDATA(s_tdata), .AXIS_S_TLAST(s_tlast), .AXIS_S_TDEST(s_tdest),
        .AXIS_M_TVALID(m_tvalid), .AXIS_M_TREADY(m_tready),
        .AXIS_M_TDATA(m_tdata), .AXIS_M_TLAST(m_tlast), .AXIS_M_TDEST(m_tdest),
        .AXIS_M_TID(m_tid), .BUSY(busy), .GRANT_IDX(grant_idx), .PKT_CNT(pkt_cnt)
    );

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    int           src_len  [NR];
    int           src_beat [NR];
    int           src_pkt  [NR];
    int           src_left [NR];
    logic [DW-1:0]  src_base [NR];
    logic [DSW-1:0] src_dest [NR];

    logic [DW-1:0]  cap_data [$];
    logic [IW-1:0]  cap_tid  [$];
    logic           cap_last [$];
    logic [DSW-1:0] cap_dest [$];
    int             cap_cyc  [$];

    logic [DW-1:0] exp3_data [10] = '{32'h0000, 32'h0001, 32'h1000, 32'h1001, 32'h2000,
                                      32'h2001, 32'h3000, 32'h3001, 32'h0100, 32'h0101};
    int            exp3_tid  [10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
    int            exp3_dest [10] = '{8, 8, 9, 9, 10, 10, 11, 11, 8, 8};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_srcs();
        for (int i = 0; i < NR; i++) begin
            s_tvalid[i]              = (src_left[i] > 0);
            s_tdata[i*DW +: DW]      = src_base[i] + 32'(src_pkt[i] * 256 + src_beat[i]);
            s_tlast[i]               = (src_beat[i] == src_len[i] - 1);
            s_tdest[i*DSW +: DSW]    = src_dest[i];
        end
    endtask

    task automatic stop_srcs();
        for (int i = 0; i < NR; i++) begin
            src_len[i]  = 1;
            src_beat[i] = 0;
            src_pkt[i]  = 0;
            src_left[i] = 0;
            src_base[i] = '0;
            src_dest[i] = '0;
        end
        drive_srcs();
        #1;
    endtask

    task automatic start_src(input int i, input int len, input int npkts,
                             input logic [DW-1:0] base, input logic [DSW-1:0] dest);
        src_len[i]  = len;
        src_beat[i] = 0;
        src_pkt[i]  = 0;
        src_left[i] = npkts;
        src_base[i] = base;
        src_dest[i] = dest;
        drive_srcs();
        #1;
    endtask

    task automatic clear_caps();
        cap_data.delete();
        cap_tid.delete();
        cap_last.delete();
        cap_dest.delete();
        cap_cyc.delete();
    endtask

    // One clock: record handshakes seen before the edge, then advance sources after it
    task automatic tick();
        logic [NR-1:0] hs;
        hs = s_tvalid & s_tready;
        if (m_tvalid && m_tready) begin
            cap_data.push_back(m_tdata);
            cap_tid.push_back(m_tid);
            cap_last.push_back(m_tlast);
            cap_dest.push_back(m_tdest);
            cap_cyc.push_back(cyc);
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < NR; i++) begin
            if (hs[i]) begin
                if (src_beat[i] == src_len[i] - 1) begin
                    src_beat[i] = 0;
                    src_pkt[i]  = src_pkt[i] + 1;
                    src_left[i] = src_left[i] - 1;
                end else begin
                    src_beat[i] = src_beat[i] + 1;
                end
            end
        end
        drive_srcs();
        #1;
    endtask

    function automatic bit srcs_pending();
        bit p;
        p = 1'b0;
        for (int i = 0; i < NR; i++) begin
            if (src_left[i] > 0) p = 1'b1;
        end
        return p;
    endfunction

    task automatic run_idle(input string tag, input int bound);
        int n;
        n = 0;
        while ((srcs_pending() || m_tvalid || busy) && n < bound) begin
            tick();
            n++;
        end
        chk(tag, 32'(n < bound), 32'd1);
    endtask

    task automatic set_ready(input logic r);
        m_tready = r;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        m_tready = 1'b1;
        s_tvalid = '0;
        s_tdata  = '0;
        s_tlast  = '0;
        s_tdest  = '0;
        stop_srcs();

        // Reset then idle
        repeat (3) tick();
        chk("rst_m_tvalid", 32'(m_tvalid), 32'd0);
        chk("rst_s_tready", 32'(s_tready), 32'd0);
        chk("rst_busy",     32'(busy), 32'd0);
        chk("rst_grant",    32'(grant_idx), 32'd0);
        chk("rst_pkt_cnt",  32'(pkt_cnt), 32'd0);
        chk("rst_m_tdata",  m_tdata, 32'd0);
        chk("rst_m_tlast",  32'(m_tlast), 32'd0);
        chk("rst_m_tdest",  32'(m_tdest), 32'd0);
        chk("rst_m_tid",    32'(m_tid), 32'd0);
        rst = 1'b0;
        repeat (2) tick();
        chk("idle_busy",     32'(busy), 32'd0);
        chk("idle_m_tvalid", 32'(m_tvalid), 32'd0);

        // Single source: req1 4-beat packet A0..A3, dest 3
        start_src(1, 4, 1, 32'hA0, 4'd3);
        tick();
        chk("t2_c1_busy",     32'(busy), 32'd1);
        chk("t2_c1_grant",    32'(grant_idx), 32'd1);
        chk("t2_c1_s_tready", 32'(s_tready), 32'b0010);
        chk("t2_c1_m_tvalid", 32'(m_tvalid), 32'd0);
        tick();
        chk("t2_c2_m_tvalid", 32'(m_tvalid), 32'd1);
        chk("t2_c2_data",     m_tdata, 32'hA0);
        chk("t2_c2_tid",      32'(m_tid), 32'd1);
        chk("t2_c2_dest",     32'(m_tdest), 32'd3);
        chk("t2_c2_last",     32'(m_tlast), 32'd0);
        tick();
        chk("t2_c3_data",     m_tdata, 32'hA1);
        chk("t2_c3_last",     32'(m_tlast), 32'd0);
        tick();
        chk("t2_c4_data",     m_tdata, 32'hA2);
        chk("t2_c4_last",     32'(m_tlast), 32'd0);
        tick();
        chk("t2_c5_data",     m_tdata, 32'hA3);
        chk("t2_c5_last",     32'(m_tlast), 32'd1);
        chk("t2_c5_busy",     32'(busy), 32'd0);
        chk("t2_c5_pkt_cnt",  32'(pkt_cnt), 32'd1);
        tick();
        chk("t2_c6_m_tvalid", 32'(m_tvalid), 32'd0);

        // All four sources with 2-beat packets from a fresh rr_ptr
        rst = 1'b1;
        stop_srcs();
        repeat (2) tick();
        rst = 1'b0;
        clear_caps();
        start_src(0, 2, 2, 32'h0000, 4'd8);
        start_src(1, 2, 1, 32'h1000, 4'd9);
        start_src(2, 2, 1, 32'h2000, 4'd10);
        start_src(3, 2, 1, 32'h3000, 4'd11);
        run_idle("t3_drain", 100);
        chk("t3_pkt_cnt", 32'(pkt_cnt), 32'd5);
        chk("t3_nbeats",  32'(cap_data.size()), 32'd10);
        for (int k = 0; k < 10 && k < cap_data.size(); k++) begin
            chk($sformatf("t3_tid%0d", k),  32'(cap_tid[k]), 32'(exp3_tid[k]));
            chk($sformatf("t3_data%0d", k), cap_data[k], exp3_data[k]);
            chk($sformatf("t3_last%0d", k), 32'(cap_last[k]), 32'(k % 2));
            chk($sformatf("t3_dest%0d", k), 32'(cap_dest[k]), 32'(exp3_dest[k]));
        end
        for (int k = 0; k < 5 && 2 * k + 1 < cap_cyc.size(); k++) begin
            chk($sformatf("t3_inpkt_gap%0d", k), 32'(cap_cyc[2*k+1] - cap_cyc[2*k]), 32'd1);
            if (2 * k + 2 < cap_cyc.size()) begin
                chk($sformatf("t3_between_gap%0d", k), 32'(cap_cyc[2*k+2] - cap_cyc[2*k+1]), 32'd2);
            end
        end

        // Back-pressure: req2 3-beat packet, M_TREADY 1,0,0,1
        clear_caps();
        start_src(2, 3, 1, 32'hB0, 4'd5);
        tick();
        chk("t4_c1_grant",    32'(grant_idx), 32'd2);
        chk("t4_c1_s_tready", 32'(s_tready), 32'b0100);
        tick();
        chk("t4_c2_data",     m_tdata, 32'hB0);
        chk("t4_c2_m_tvalid", 32'(m_tvalid), 32'd1);
        set_ready(1'b0);
        chk("t4_c2_stall_rdy", 32'(s_tready), 32'd0);
        tick();
        chk("t4_c3_data",     m_tdata, 32'hB0);
        chk("t4_c3_m_tvalid", 32'(m_tvalid), 32'd1);
        chk("t4_c3_stall_rdy", 32'(s_tready), 32'd0);
        chk("t4_c3_busy",     32'(busy), 32'd1);
        tick();
        chk("t4_c4_data",     m_tdata, 32'hB0);
        set_ready(1'b1);
        chk("t4_c4_s_tready", 32'(s_tready), 32'b0100);
        tick();
        chk("t4_c5_data",     m_tdata, 32'hB1);
        tick();
        chk("t4_c6_data",     m_tdata, 32'hB2);
        chk("t4_c6_last",     32'(m_tlast), 32'd1);
        chk("t4_c6_busy",     32'(busy), 32'd0);
        chk("t4_c6_pkt_cnt",  32'(pkt_cnt), 32'd6);
        tick();
        chk("t4_c7_m_tvalid", 32'(m_tvalid), 32'd0);
        chk("t4_nbeats",      32'(cap_data.size()), 32'd3);
        for (int k = 0; k < 3 && k < cap_data.size(); k++) begin
            chk($sformatf("t4_beat%0d", k), cap_data[k], 32'hB0 + 32'(k));
        end

        // Single-beat packet from req0, leaves rr_ptr at 1
        start_src(0, 1, 1, 32'hE0, 4'd1);
        tick();
        chk("t5a_grant", 32'(grant_idx), 32'd0);
        chk("t5a_busy",  32'(busy), 32'd1);
        tick();
        chk("t5a_busy_after", 32'(busy), 32'd0);
        chk("t5a_m_tvalid",   32'(m_tvalid), 32'd1);
        chk("t5a_last",       32'(m_tlast), 32'd1);
        chk("t5a_data",       m_tdata, 32'hE0);
        chk("t5a_pkt_cnt",    32'(pkt_cnt), 32'd7);
        tick();
        chk("t5a_drained",    32'(m_tvalid), 32'd0);

        // Skip: only req3 valid with rr_ptr=1 -> grant 3 directly
        start_src(3, 1, 1, 32'hF3, 4'd2);
        tick();
        chk("t5b_grant", 32'(grant_idx), 32'd3);
        tick();
        chk("t5b_tid",     32'(m_tid), 32'd3);
        chk("t5b_data",    m_tdata, 32'hF3);
        chk("t5b_pkt_cnt", 32'(pkt_cnt), 32'd8);
        tick();
        clear_caps();

        // req0 and req1 together after rr_ptr wrapped to 0 -> grant 0 then 1
        start_src(0, 1, 1, 32'h50, 4'd4);
        start_src(1, 1, 1, 32'h51, 4'd4);
        tick();
        chk("t5c_grant0", 32'(grant_idx), 32'd0);
        tick();
        tick();
        chk("t5c_grant1", 32'(grant_idx), 32'd1);
        chk("t5c_busy",   32'(busy), 32'd1);
        run_idle("t5c_drain", 50);
        chk("t5c_nbeats",  32'(cap_data.size()), 32'd2);
        if (cap_data.size() >= 2) begin
            chk("t5c_tid0",  32'(cap_tid[0]), 32'd0);
            chk("t5c_tid1",  32'(cap_tid[1]), 32'd1);
            chk("t5c_data1", cap_data[1], 32'h51);
        end
        chk("t5c_pkt_cnt", 32'(pkt_cnt), 32'd10);

        // Reset on the 2nd beat of a 4-beat packet
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_pkt_cnt_rst", 32'(pkt_cnt), 32'd0);
        start_src(1, 4, 1, 32'hC0, 4'd7);
        tick();
        chk("t6_grant", 32'(grant_idx), 32'd1);
        tick();
        chk("t6_beat0", m_tdata, 32'hC0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_m_tvalid", 32'(m_tvalid), 32'd0);
        chk("t6_busy",     32'(busy), 32'd0);
        chk("t6_pkt_cnt",  32'(pkt_cnt), 32'd0);
        chk("t6_s_tready", 32'(s_tready), 32'd0);
        stop_srcs();
        clear_caps();
        start_src(1, 2, 1, 32'hD0, 4'd7);
        tick();
        chk("t6_regrant", 32'(grant_idx), 32'd1);
        run_idle("t6_drain", 50);
        chk("t6_nbeats", 32'(cap_data.size()), 32'd2);
        if (cap_data.size() >= 2) begin
            chk("t6_data0", cap_data[0], 32'hD0);
            chk("t6_data1", cap_data[1], 32'hD1);
            chk("t6_tid1",  32'(cap_tid[1]), 32'd1);
            chk("t6_last1", 32'(cap_last[1]), 32'd1);
        end
        chk("t6_pkt_cnt_end", 32'(pkt_cnt), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
